stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Control sequencer for the stopwatch time datapath. It converts the debounced start/stop, program, clear and increment controls into a mode state machine. It generates the 1 ms count-step pulse and holds the programmed countdown preset. It drives the alarm request to the sound module when a countdown expires. It sits between the board I/O block and the stopwatch counter datapath, which only obeys `cnt_step`, `cnt_up` and `cnt_init`.

## Interface
- `TICK_DIV`, default 100000: clk cycles per 1 ms step (100 MHz board clock).
- `DEFAULT_PRESET`, default 30000: countdown preset in ms after reset.
- `PRESET_MAX`, default 5999000: preset saturation limit in ms (99:59).
- `ALARM_MS`, default 2000: alarm duration in ms steps.

- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s` in 1: start/stop button level, debounced and synchronous.
- `p` in 1: program mode level; 1 = programming.
- `u` in 1: direction switch; 1 = count up, 0 = count down.
- `clr` in 1: time-clear button level.
- `inc` in 1: preset increment button level.
- `min` in 1: increment unit; 1 = minutes (60000 ms), 0 = seconds (1000 ms).
- `cnt_zero` in 1: datapath time equals 0.
- `cnt_step` out 1: one-cycle pulse; the datapath advances 1 ms.
- `cnt_up` out 1: latched direction for the datapath.
- `cnt_init` out 1: one-cycle pulse; the datapath loads 0 if `cnt_up`=1, else loads `preset`.
- `preset` out 23: countdown preset in ms.
- `state` out 3: IDLE=0, RUN=1, PAUSE=2, PROG=3, EXPIRED=4.
- `alarm` out 1: beep request (the codebase's `zero` net).

## Operation
- Edge detection: `s`, `clr` and `inc` are each registered once. A rise is the current sample = 1 while the registered sample = 0. Level-held buttons give exactly one rise.
- Priority, highest first: `rst`, `p`, `clr` rise, `s` rise, `cnt_zero` / prescaler events.
- IDLE:
  - `s` rise: latch `cnt_up` <= `u`, clear the prescaler, go to RUN.
  - `clr` rise: pulse `cnt_init`, stay in IDLE.
- RUN:
  - Prescaler counts 0..TICK_DIV-1; on reaching TICK_DIV-1 it wraps and `cnt_step` pulses.
  - If `cnt_up`=0 and `cnt_zero`=1: go to EXPIRED, no step is issued, the alarm counter loads ALARM_MS.
  - `s` rise: go to PAUSE.
  - `clr` rise: go to IDLE and pulse `cnt_init`.
- PAUSE:
  - Prescaler value is held.
  - `s` rise: go to RUN, resuming the prescaler without clearing it. `cnt_up` is not relatched.
  - `clr` rise: go to IDLE and pulse `cnt_init`.
- EXPIRED:
  - `alarm`=1 while the alarm counter is nonzero. The counter decrements on each prescaler wrap; the prescaler free-runs in this state.
  - `s` rise or `clr` rise: go to IDLE, pulse `cnt_init`, drop `alarm`.
- PROG:
  - Entered from any state while `p`=1. `alarm` drops and no steps are issued.
  - `inc` rise adds 60000 if `min`=1, else 1000. The result saturates at PRESET_MAX; an add that would exceed the limit sets `preset`=PRESET_MAX.
  - On `p` falling to 0: go to IDLE and pulse `cnt_init` with `cnt_up` <= `u`.
- `inc` outside PROG is ignored. A `u` change while RUN/PAUSE is ignored until the next IDLE→RUN transition.
- Preset arithmetic is unsigned 23-bit; the compare against PRESET_MAX is done before any overflow can occur.

## Timing
- Reset values: `state`=IDLE, `preset`=DEFAULT_PRESET, `cnt_up`=1, `cnt_step`=0, `cnt_init`=0, `alarm`=0, prescaler=0, alarm counter=0, edge registers=0.
- All outputs are registered.
- Button latency: a rise sampled at edge N changes `state` and `cnt_init` visibly after edge N.
- First `cnt_step` occurs TICK_DIV cycles after entering RUN from IDLE.
- Steps arrive exactly every TICK_DIV cycles while in RUN.
- `cnt_init` and `cnt_step` are never asserted in the same cycle.
- `rst` mid-operation aborts any state within one edge.
- Expiry: `cnt_zero` sampled 1 in RUN (down mode) at edge N gives `state`=EXPIRED and `alarm`=1 after edge N.

## Test plan
- Count up, TICK_DIV=4: `u`=1, `s` pulse → RUN; `cnt_step` fires every 4 cycles; second `s` pulse → PAUSE with no steps; third `s` pulse → RUN with the step phase preserved.
- Countdown expiry, TICK_DIV=4, ALARM_MS=3: `u`=0, run, force `cnt_zero`=1 → EXPIRED, `alarm` high for 12 cycles, no `cnt_step`; `s` pulse → IDLE plus one `cnt_init`.
- Program: `p`=1, `min`=1, one `inc` rise, then `min`=0 and six `inc` rises → `preset`=30000+60000+6000=96000; `p`=0 → IDLE plus one `cnt_init`, `cnt_up`=`u`.
- Saturation: with `preset`=5990000, one minute `inc` → 5999000; a further `inc` → unchanged.
- Priority: `s` and `clr` rise together in PAUSE → IDLE with `cnt_init`; `p`=1 during RUN → PROG immediately, steps stop.
- Reset mid-run: `rst` for one cycle in EXPIRED → all outputs at reset values on the next cycle, `preset`=30000.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: mode sequencer for the stopwatch time datapath.
//   Turns debounced start/stop, program, clear and increment levels into a
//   mode FSM, generates the 1 ms count-step pulse, holds the countdown preset
//   and raises the alarm request when a countdown expires.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   s, p, u, clr        start/stop, program level, direction, clear
//   inc, min            preset increment button and unit (1 = minute)
//   cnt_zero            datapath time is zero
//   cnt_step, cnt_init  one-cycle step / load pulses to the datapath
//   cnt_up              latched count direction
//   preset              countdown preset in ms
//   state               IDLE=0 RUN=1 PAUSE=2 PROG=3 EXPIRED=4
//   alarm               beep request
module stopwatch_ctrl #(
  parameter int TICK_DIV       = 100000,
  parameter int DEFAULT_PRESET = 30000,
  parameter int PRESET_MAX     = 5999000,
  parameter int ALARM_MS       = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s,
  input  logic        p,
  input  logic        u,
  input  logic        clr,
  input  logic        inc,
  input  logic        min,
  input  logic        cnt_zero,
  output logic        cnt_step,
  output logic        cnt_up,
  output logic        cnt_init,
  output logic [22:0] preset,
  output logic [2:0]  state,
  output logic        alarm
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    PAUSE   = 3'd2,
    PROG    = 3'd3,
    EXPIRED = 3'd4
  } state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = (ALARM_MS > 0) ? $clog2(ALARM_MS + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ALARM_LOAD = AW'(ALARM_MS);
  localparam logic [AW-1:0] ALARM_ONE  = AW'(1);
  localparam logic [22:0]   PRESET_RST = 23'(DEFAULT_PRESET);
  localparam logic [22:0]   PMAX       = 23'(PRESET_MAX);
  localparam logic [22:0]   ADD_MIN    = 23'd60000;
  localparam logic [22:0]   ADD_SEC    = 23'd1000;

  state_t        st;
  logic [PW-1:0] presc;
  logic [AW-1:0] acnt;
  logic          s_q, clr_q, inc_q;

  logic          s_rise, clr_rise, inc_rise, presc_wrap, sat;
  logic [22:0]   add_amt, preset_next;

  assign s_rise     = s & ~s_q;
  assign clr_rise   = clr & ~clr_q;
  assign inc_rise   = inc & ~inc_q;
  assign presc_wrap = (presc == PRESC_LAST);
  assign state      = st;

  // Headroom compare keeps the add from ever wrapping 23 bits.
  assign add_amt     = min ? ADD_MIN : ADD_SEC;
  assign sat         = (PMAX < add_amt) || (preset > (PMAX - add_amt));
  assign preset_next = sat ? PMAX : (preset + add_amt);

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      preset   <= PRESET_RST;
      cnt_up   <= 1'b1;
      cnt_step <= 1'b0;
      cnt_init <= 1'b0;
      alarm    <= 1'b0;
      presc    <= '0;
      acnt     <= '0;
      s_q      <= 1'b0;
      clr_q    <= 1'b0;
      inc_q    <= 1'b0;
    end else begin
      s_q      <= s;
      clr_q    <= clr;
      inc_q    <= inc;
      cnt_step <= 1'b0;
      cnt_init <= 1'b0;
      if (p) begin
        // Program level overrides every mode; only increments act here.
        st    <= PROG;
        alarm <= 1'b0;
        acnt  <= '0;
        if (st == PROG && inc_rise) preset <= preset_next;
      end else begin
        unique case (st)
          PROG: begin
            st       <= IDLE;
            cnt_init <= 1'b1;
            cnt_up   <= u;
          end
          IDLE: begin
            if (clr_rise) begin
              cnt_init <= 1'b1;
            end else if (s_rise) begin
              cnt_up <= u;
              presc  <= '0;
              st     <= RUN;
            end
          end
          RUN: begin
            if (clr_rise) begin
              st       <= IDLE;
              cnt_init <= 1'b1;
            end else if (s_rise) begin
              st <= PAUSE;
            end else if (!cnt_up && cnt_zero) begin
              // Restart the prescaler so the alarm lasts exactly ALARM_MS steps.
              st    <= EXPIRED;
              presc <= '0;
              acnt  <= ALARM_LOAD;
              alarm <= (ALARM_LOAD != '0);
            end else if (presc_wrap) begin
              presc    <= '0;
              cnt_step <= 1'b1;
            end else begin
              presc <= presc + 1'b1;
            end
          end
          PAUSE: begin
            if (clr_rise) begin
              st       <= IDLE;
              cnt_init <= 1'b1;
            end else if (s_rise) begin
              st <= RUN;
            end
          end
          EXPIRED: begin
            if (s_rise || clr_rise) begin
              st       <= IDLE;
              cnt_init <= 1'b1;
              alarm    <= 1'b0;
              acnt     <= '0;
            end else begin
              presc <= presc_wrap ? '0 : (presc + 1'b1);
              if (presc_wrap && acnt != '0) begin
                acnt  <= acnt - 1'b1;
                alarm <= (acnt != ALARM_ONE);
              end
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule
